hamming_decoder_stream: RTL and testbench

Streaming Hamming(7,4) single-error-correcting decoder. It is the receive-side counterpart of the team's Hamming encoder and uses the same codeword layout: ham[0]=p1, ham[1]=p2, ham[2]=d0, ham[3]=p4, ham[4]=d1, ham[5]=d2, ham[6]=d3. It accepts codewords over a valid/ready interface and passes them through a 2-stage pipeline with full backpressure. It emits the corrected 4-bit data with error status, and keeps saturating statistics counters for link monitoring.

---
 rtl/hamming_decoder_stream.sv | 131 +++++++++++++
 tb/tb_hamming_decoder_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder_stream.sv
// hamming_decoder_stream
//   Streaming Hamming(7,4) single-error-correcting decoder with a two-stage
//   valid/ready pipeline and saturating link statistics.
//
//   Codeword layout: [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3
//
//   Ports
//     clk, rst        clock and synchronous active-high reset
//     in_valid/ready  input handshake, in_code = received 7-bit codeword
//     out_valid/ready output handshake
//     out_data        corrected data {d3,d2,d1,d0}
//     out_err_pos     syndrome, 0 = clean, else 1-based flipped bit position
//     out_corrected   nonzero syndrome, one bit was flipped
//     cnt_clr         synchronous clear of both counters (wins over increment)
//     corr_cnt        saturating count of corrected words delivered
//     word_cnt        saturating count of all words delivered
//
//   Every nonzero syndrome is treated as a single-bit error; double errors
//   are miscorrected by design.
module hamming_decoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_err_pos,
    output logic             out_corrected,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
        logic s0;
        logic s1;
        logic s2;
        s0 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s1 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s2 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s2, s1, s0};
    endfunction

    // Flip bit (syn-1); syn is at most 7 so the index stays inside [6:0].
    function automatic logic [6:0] correct_code(input logic [6:0] c,
                                                input logic [2:0] syn);
        logic [6:0] fixed;
        logic [2:0] idx;
        fixed = c;
        idx   = syn - 3'd1;
        if (syn != 3'd0) begin
            fixed[idx] = ~fixed[idx];
        end
        return fixed;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic       vld_p1;
    logic [6:0] code_p1;
    logic [2:0] syn_p1;
    logic [6:0] fixed_p1;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic out_fire;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = vld_p1 && s2_adv;
    assign in_ready = !vld_p1 || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign fixed_p1 = correct_code(code_p1, syn_p1);

    // ---- stage 1: capture codeword and syndrome ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
        end else if (s1_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            code_p1 <= in_code;
            syn_p1  <= calc_syndrome(in_code);
        end
    end

    // ---- stage 2: corrected output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= 4'd0;
            out_err_pos   <= 3'd0;
            out_corrected <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= vld_p1;
            // Data only moves when a word arrives; idle outputs keep their last value.
            if (s1_adv) begin
                out_data      <= {fixed_p1[6], fixed_p1[5], fixed_p1[4], fixed_p1[2]};
                out_err_pos   <= syn_p1;
                out_corrected <= (syn_p1 != 3'd0);
            end
        end
    end

    // ---- statistics on delivered words ----
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (out_fire) begin
            word_cnt <= sat_inc(word_cnt);
            if (out_corrected) begin
                corr_cnt <= sat_inc(corr_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hamming_decoder_stream.sv
module tb_hamming_decoder_stream;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] p;
        logic       c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_code = 7'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_data;
    logic [2:0]  out_err_pos;
    logic        out_corrected;
    logic        cnt_clr = 1'b0;
    logic [15:0] corr_cnt;
    logic [15:0] word_cnt;

    logic        in_ready3;
    logic        out_valid3;
    logic [3:0]  out_data3;
    logic [2:0]  out_err_pos3;
    logic        out_corrected3;
    logic [2:0]  corr_cnt3;
    logic [2:0]  word_cnt3;

    int   n_vec = 0;
    int   n_bad = 0;
    int   orm   = 0;   // out_ready mode: 0 high, 1 low, 2 random
    exp_t cur_exp;
    exp_t q[$];

    hamming_decoder_stream #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err_pos(out_err_pos),
        .out_corrected(out_corrected), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .word_cnt(word_cnt)
    );

    hamming_decoder_stream #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_code(in_code), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .out_err_pos(out_err_pos3),
        .out_corrected(out_corrected3), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt3), .word_cnt(word_cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Advance one clock; inputs change #1 after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (orm == 2) out_ready = 1'($urandom_range(0, 1));
        else          out_ready = (orm == 0);
    endtask

    task automatic send(input logic [6:0] code, input logic [3:0] d,
                        input logic [2:0] p);
        logic fired;
        fired    = 1'b0;
        cur_exp  = '{d: d, p: p, c: (p != 3'd0)};
        in_code  = code;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !fired; i++) begin
            @(negedge clk);
            fired = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        if (!fired) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            cyc();
            done = (q.size() == 0);
        end
        if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: outputs popped before new inputs pushed, both on the
    // falling edge where every input is stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_err_pos", 32'(out_err_pos), 32'(e.p));
                        chk("out_corrected", 32'(out_corrected), 32'(e.c));
                    end
                end
                if (in_valid && in_ready) q.push_back(cur_exp);
            end
        end
    end

    initial begin
        logic [3:0] d;
        logic [6:0] cw;
        int         k;
        int         inj;

        // Reset state
        repeat (3) cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err_pos", 32'(out_err_pos), 32'd0);
        chk("rst_corrected", 32'(out_corrected), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Clean word and latency
        send(7'h55, 4'b1011, 3'd0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        drain();
        chk("clean_word_cnt", 32'(word_cnt), 32'd1);
        chk("clean_corr_cnt", 32'(corr_cnt), 32'd0);

        // Single error on each position
        for (int b = 0; b < 7; b++) begin
            cw = 7'h55 ^ (7'd1 << b);
            send(cw, 4'b1011, 3'(b + 1));
        end
        drain();
        chk("single_corr_cnt", 32'(corr_cnt), 32'd7);
        chk("single_word_cnt", 32'(word_cnt), 32'd8);

        // Backpressure
        orm = 1;
        cyc();
        send(7'h00, 4'h0, 3'd0);
        send(7'h01, 4'h0, 3'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'({out_data, out_err_pos}), 32'd0);
            cyc();
        end
        orm = 0;
        send(7'h55, 4'hB, 3'd0);
        send(7'h54, 4'hB, 3'd1);
        drain();
        chk("bp_word_cnt", 32'(word_cnt), 32'd12);

        // Saturation with CNT_W=3 and clear
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("clr_idle_word", 32'(word_cnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            d  = 4'($urandom_range(0, 15));
            k  = $urandom_range(0, 6);
            send(encode(d) ^ (7'd1 << k), d, 3'(k + 1));
        end
        drain();
        chk("sat_corr3", 32'(corr_cnt3), 32'd7);
        chk("sat_word3", 32'(word_cnt3), 32'd7);
        chk("sat_corr16", 32'(corr_cnt), 32'd10);
        chk("sat_word16", 32'(word_cnt), 32'd10);
        orm = 1;
        cyc();
        send(7'h45, 4'hB, 3'd5);
        cyc();
        cyc();
        chk("clr_hs_pending", 32'(out_valid), 32'd1);
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        orm       = 0;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_hs_word16", 32'(word_cnt), 32'd0);
        chk("clr_hs_corr16", 32'(corr_cnt), 32'd0);
        chk("clr_hs_word3", 32'(word_cnt3), 32'd0);
        chk("clr_hs_corr3", 32'(corr_cnt3), 32'd0);
        chk("clr_hs_consumed", 32'(q.size()), 32'd0);

        // Full-rate random with random flow control
        orm = 2;
        inj = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 6);
                inj++;
                send(encode(d) ^ (7'd1 << k), d, 3'(k + 1));
            end else begin
                send(encode(d), d, 3'd0);
            end
        end
        orm = 0;
        drain();
        chk("rand_word_cnt", 32'(word_cnt), 32'd1000);
        chk("rand_corr_cnt", 32'(corr_cnt), 32'(inj));

        // Reset with two words in flight
        orm = 1;
        cyc();
        send(7'h55, 4'hB, 3'd0);
        send(7'h54, 4'hB, 3'd1);
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        orm = 0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_word", 32'(word_cnt), 32'd0);
        chk("mid_rst_corr", 32'(corr_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end
        chk("mid_final_word", 32'(word_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
